uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter ADDR_W, default 14, word-address width of the target memory.
REQ-003 clk  input  1  single clock domain; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 wr_en  output  1  one-cycle memory write strobe.
REQ-007 wr_addr  output  ADDR_W  word address of the current write.
REQ-008 wr_data  output  32  word to write; valid only while wr_en=1.
REQ-009 busy  output  1  high from first header byte received until load complete.
REQ-010 done  output  1  high once all words are written; held until reset.
REQ-011 frame_err  output  1  sticky; set on any stop bit sampled low.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; its latency is counted from the synchronized signal.
REQ-013 Byte receiver states: IDLE, START, DATA, STOP.
REQ-014 IDLE->START on synchronized rx=0.
REQ-015 START: resample at CLKS_PER_BIT/2; rx=1 -> IDLE (glitch, no byte); rx=0 -> DATA.
REQ-016 DATA: sample 8 bits, each CLKS_PER_BIT after the previous sample, LSB first.
REQ-017 STOP: sample once after a further CLKS_PER_BIT; rx=1 -> byte valid one cycle; rx=0 -> frame_err set, byte discarded. Both paths -> IDLE.
REQ-018 Loader states: HDR0, HDR1, LOAD, DONE; reset state HDR0.
REQ-019 HDR0 takes count[7:0]; HDR1 takes count[15:8]; stream = 16-bit word count N, little-endian.
REQ-020 LOAD assembles 4 bytes little-endian (first byte -> wr_data[7:0]).
REQ-021 wr_en SHALL pulse exactly one cycle, in the cycle after the 4th byte-valid.
REQ-022 wr_addr SHALL start at 0 and increment by 1 after each write; it wraps modulo 2^ADDR_W.
REQ-023 After the Nth write -> DONE; done=1, busy=0 from the next cycle.
REQ-024 N=0: HDR1 -> DONE directly; no write issued.
REQ-025 DONE SHALL ignore all further bytes until reset.
REQ-026 A discarded (framing-error) byte SHALL NOT advance the header or word byte counters.
REQ-027 busy SHALL go high the cycle after the HDR0 byte-valid.

Reset
REQ-028 When rst=0 at a clk edge: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0; receiver->IDLE; loader->HDR0; partial word and counters cleared.
REQ-029 Reset mid-byte or mid-load SHALL abandon the transfer with no further wr_en; after release the block waits for a fresh header.

Structure
REQ-030 Receiver and loader state encodings and the default CLKS_PER_BIT SHALL live in the shared definitions include.
REQ-031 The byte receiver SHALL be the sub-module uart_rx_byte (ports clk, rst, rx, byte_valid, byte_data, frame_err); loader logic stays in uart_prog_loader.

Verification (CLKS_PER_BIT=16)
REQ-032 Send header 0x02,0x00 then bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> wr_en at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; done=1; exactly 2 strobes.
REQ-033 Header 0x00,0x00 -> no wr_en; done=1, busy=0 after the second byte.
REQ-034 rx low pulse of 4 cycles while IDLE -> no byte accepted; loader stays in HDR0, busy=0.
REQ-035 During N=1, third data byte sent with stop bit 0 -> frame_err=1; byte ignored; a resend of the byte plus 4th byte -> single write with the correct word.
REQ-036 rst=0 held for 1 cycle after 2 of 4 data bytes -> all outputs 0; a new full stream then writes from addr 0.
REQ-037 After done, send 4 extra bytes -> no wr_en; done stays 1.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// ============================================================================
// Module   : uart_prog_loader_pkg
// Brief    : Shared state encodings and default bit timing for the UART loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_prog_loader_pkg;

    localparam int unsigned c_default_clks_per_bit = 868;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_HDR0 = 2'd0,
        LD_HDR1 = 2'd1,
        LD_LOAD = 2'd2,
        LD_DONE = 2'd3
    } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_prog_loader_rx.sv
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART byte receiver with input synchronizer and sticky frame error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    logic                rx_meta_q, rx_sync_q;
    rx_state_t           state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                ferr_q, ferr_d;
    logic                w_half, w_full;

    assign w_half = (cnt_q == c_cnt_w'(CLKS_PER_BIT / 2 - 1));
    assign w_full = (cnt_q == c_cnt_w'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + c_cnt_w'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ferr_d  = ferr_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (w_half) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_full) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign frame_err  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// ============================================================================
// Module   : uart_prog_loader
// Brief    : Loads a length-prefixed little-endian word stream from UART into memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (frame_err)
    );

    ld_state_t         state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       part_q, part_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LD_HDR0;
            count_q   <= '0;
            idx_q     <= '0;
            part_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            part_q    <= part_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        part_d    = part_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            LD_HDR0: begin
                if (w_byte_valid) begin
                    count_d[7:0] = w_byte_data;
                    busy_d       = 1'b1;
                    state_d      = LD_HDR1;
                end
            end
            LD_HDR1: begin
                if (w_byte_valid) begin
                    count_d[15:8] = w_byte_data;
                    idx_d         = '0;
                    if ({w_byte_data, count_q[7:0]} == 16'd0) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                // count_q holds words still to write; zero while strobing means last word.
                if (wr_en_q && count_q == 16'd0) begin
                    state_d = LD_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (w_byte_valid) begin
                    if (idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {w_byte_data, part_q};
                        count_d   = count_q - 16'd1;
                        idx_d     = '0;
                    end else begin
                        part_d[8*idx_q +: 8] = w_byte_data;
                        idx_d                = idx_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ============================================================================
// Module   : tb_uart_prog_loader
// Brief    : Randomized self-checking bench with a stream-level write model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_wr_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Stream rules: N = first two bytes LE; word k = bytes 2+4k..5+4k LE at address k mod 2^AW.
    function automatic int stream_n(input bq_t s);
        return (s.size() < 2) ? 0 : int'(s[0]) + 256 * int'(s[1]);
    endfunction

    function automatic bit exp_done(input bq_t s);
        return (s.size() >= 2) && (stream_n(s) <= (s.size() - 2) / 4);
    endfunction

    task automatic model_stream(input bq_t s);
        wr_t w;
        int  n     = stream_n(s);
        int  avail = (s.size() >= 2) ? (s.size() - 2) / 4 : 0;
        for (int k = 0; k < n && k < avail; k++) begin
            w.addr = AW'(k);
            w.data = {s[5+4*k], s[4+4*k], s[3+4*k], s[2+4*k]};
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_en) begin
            check("wr_en_one_cycle", {31'd0, prev_wr_en}, 32'd0);
            check("write_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("wr_addr", {{(32-AW){1'b0}}, wr_addr}, {{(32-AW){1'b0}}, exp_q[0].addr});
                check("wr_data", wr_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            obs_log.push_back('{wr_addr, wr_data});
        end
        prev_wr_en = wr_en;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat ((stop_ok ? 0 : CPB) + $urandom_range(1, 20)) @(negedge clk);
    endtask

    task automatic send_stream(input bq_t s);
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_addr"}, {{(32-AW){1'b0}}, wr_addr}, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic do_reset(input bit chk, input string tag);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        if (chk) check_outputs_zero(tag);
        @(negedge clk) rst = 1'b1;
        exp_q.delete();
        obs_log.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_check(input string tag, input bq_t s);
        bit d = exp_done(s);
        repeat (40) @(negedge clk);
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, (s.size() >= 1) && !d});
    endtask

    task automatic random_stream(output bq_t s, input int n, input int extra);
        s.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n + extra; i++) s.push_back(8'($urandom));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         s;
        logic [31:0] w;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Short low glitch while idle must not be taken as a byte.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_done", {31'd0, done}, 32'd0);
        check("glitch_writes", obs_log.size(), 32'd0);

        s = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_stream(s);
        check("model_count", exp_q.size(), 32'd2);
        check("model_word0", exp_q[0].data, 32'h1234_5678);
        check("model_word1", exp_q[1].data, 32'hDEAD_BEEF);
        send_byte(s[0], 1'b1);
        check("busy_after_hdr0", {31'd0, busy}, 32'd1);
        check("done_after_hdr0", {31'd0, done}, 32'd0);
        for (int i = 1; i < s.size(); i++) send_byte(s[i], 1'b1);
        finish_check("basic", s);
        check("basic_strobes", obs_log.size(), 32'd2);
        if (obs_log.size() == 2) begin
            check("basic_addr1", {{(32-AW){1'b0}}, obs_log[1].addr}, 32'd1);
            check("basic_data1", obs_log[1].data, 32'hDEAD_BEEF);
        end

        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        repeat (40) @(negedge clk);
        check("after_done_strobes", obs_log.size(), 32'd2);
        check("after_done_done", {31'd0, done}, 32'd1);

        do_reset(1'b0, "r0");
        s = {8'h00, 8'h00};
        model_stream(s);
        send_stream(s);
        finish_check("n0", s);
        check("n0_strobes", obs_log.size(), 32'd0);

        // Framing error on the third data byte, then a clean resend.
        do_reset(1'b0, "r1");
        w = $urandom;
        s = {8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24]};
        model_stream(s);
        for (int i = 0; i < 4; i++) send_byte(s[i], 1'b1);
        send_byte(~s[4], 1'b0);
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        check("frame_err_no_write", obs_log.size(), 32'd0);
        send_byte(s[4], 1'b1);
        send_byte(s[5], 1'b1);
        finish_check("ferr", s);
        check("ferr_strobes", obs_log.size(), 32'd1);
        if (obs_log.size() == 1) check("ferr_word", obs_log[0].data, w);

        // Reset in the middle of a word abandons the load.
        do_reset(1'b0, "r2");
        s = {8'h02, 8'h00, 8'($urandom), 8'($urandom)};
        model_stream(s);
        send_stream(s);
        do_reset(1'b1, "midload");
        check("midload_no_write", obs_log.size(), 32'd0);
        random_stream(s, 3, 0);
        model_stream(s);
        send_stream(s);
        finish_check("after_midload", s);
        check("after_midload_strobes", obs_log.size(), 32'd3);

        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0, "rr");
            random_stream(s, $urandom_range(1, 3), $urandom_range(0, 2));
            model_stream(s);
            send_stream(s);
            finish_check("random", s);
        end

        // Ten words over an 8-word address space: addresses wrap after 7.
        do_reset(1'b0, "r3");
        random_stream(s, 10, 0);
        model_stream(s);
        send_stream(s);
        finish_check("wrap", s);
        check("wrap_strobes", obs_log.size(), 32'd10);
        if (obs_log.size() == 10) check("wrap_addr8", {{(32-AW){1'b0}}, obs_log[8].addr}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
